line_drawer: RTL and testbench
==============================

LINE_DRAWER -- requirements
Module: line_drawer

Interface
REQ-001 Parameter CW, default 9, coordinate width in bits; all coordinate ports are CW bits wide, unsigned.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to draw; sampled only in IDLE.
REQ-005 x0, y0  input  CW  line start point; latched when start is accepted.
REQ-006 x1, y1  input  CW  line end point; latched when start is accepted.
REQ-007 plot_valid  output  1  px/py holds a valid pixel.
REQ-008 plot_ready  input  1  consumer accepts the pixel; a transfer occurs when plot_valid && plot_ready at a rising edge.
REQ-009 px, py  output  CW  current pixel coordinate.
REQ-010 busy  output  1  high in SETUP, DRAW and DONE.
REQ-011 done  output  1  one-cycle pulse after the final pixel transfer.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, SETUP, DRAW, DONE.
REQ-013 IDLE -> SETUP when start=1; start SHALL be ignored in every other state.
REQ-014 SETUP (1 cycle): register sx=+1 if x1>=x0 else -1, and sy likewise; dx=|x1-x0|; dy=-|y1-y0|; err=dx+dy; px=x0, py=y0.
REQ-015 SETUP -> DRAW unconditionally; plot_valid SHALL first be high in the cycle two edges after the edge that sampled start.
REQ-016 In DRAW, plot_valid=1; px/py SHALL stay stable while plot_valid=1 and plot_ready=0.
REQ-017 On each transfer in DRAW: if (px,py)==(x1,y1), go to DONE; otherwise with e2=2*err: if e2>=dy then err+=dy, px+=sx; if e2<=dx then err+=dx, py+=sy. Both updates SHALL apply in the same cycle when both conditions hold.
REQ-018 dx, dy, err and e2 SHALL be signed, CW+3 bits wide, so that no overflow occurs for any CW-bit endpoints.
REQ-019 With plot_ready held high, DRAW SHALL emit exactly max(|x1-x0|,|y1-y0|)+1 pixels, one per cycle, first (x0,y0), last (x1,y1), with no duplicates.
REQ-020 Consecutive emitted pixels SHALL differ by at most 1 in each axis.
REQ-021 DONE (1 cycle): done=1, plot_valid=0; then DONE -> IDLE.
REQ-022 Degenerate line (x0==x1, y0==y1) SHALL emit exactly one pixel, then DONE.
REQ-023 Input changes after acceptance SHALL NOT affect the line in progress.
REQ-024 A start asserted in the DONE cycle SHALL be ignored; a start held into the following IDLE cycle SHALL be accepted.

Reset
REQ-025 Reset_n=0 SHALL immediately force IDLE, plot_valid=0, busy=0, done=0, px=0, py=0 and clear internal registers, regardless of clock.
REQ-026 Reset asserted mid-DRAW SHALL abort the line; no further pixels and no done pulse; after release the block SHALL accept a new start normally.

Verification
REQ-027 Horizontal line: (2,5)->(6,5), ready=1 -> pixels (2,5),(3,5),(4,5),(5,5),(6,5) on 5 consecutive cycles, then done pulse.
REQ-028 Steep reverse line: (3,9)->(1,3), ready=1 -> 7 pixels, y strictly decreasing 9..3, x non-increasing 3..1, last (1,3).
REQ-029 Backpressure: (0,0)->(4,4) with ready toggling 1,0,0,1,... -> pixels (0,0)..(4,4) each held stable while ready=0, no pixel lost or repeated.
REQ-030 Single point: (511,511)->(511,511) -> exactly one pixel (511,511), done one cycle after its transfer.
REQ-031 Extreme span: (0,0)->(511,1) -> 512 pixels, x 0..511, y changes from 0 to 1 exactly once; no overflow.
REQ-032 Reset mid-draw: (0,0)->(100,0), Reset_n low after the 10th transfer -> outputs reset asynchronously, no done; a new start (1,1)->(2,2) then draws (1,1),(2,2).

Source files
------------

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: latches two endpoints on start and streams one pixel
// per accepted valid/ready transfer, first (x0,y0) through last (x1,y1), then pulses done.
module line_drawer #(
    parameter int CW = 9
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] y0,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] y1,
    output logic          plot_valid,
    input  logic          plot_ready,
    output logic [CW-1:0] px,
    output logic [CW-1:0] py,
    output logic          busy,
    output logic          done,
    output logic [1:0]    o_dbg_state
);

    localparam int EW = CW + 3;
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]        r_x0, r_y0, r_x1, r_y1;
    logic [CW-1:0]        r_px, r_py;
    logic                 r_sx_neg, r_sy_neg;
    logic signed [EW-1:0] r_dx, r_dy, r_err;

    logic [CW-1:0]        w_dx_abs, w_dy_abs;
    logic signed [EW-1:0] w_e2, w_err_a, w_err_n;
    logic                 w_xfer, w_last, w_step_x, w_step_y;

    // plot_valid/plot_ready: a pixel transfers on a rising edge where both are high;
    // px/py are only updated by a transfer, so they hold while the consumer stalls.
    assign w_xfer   = (r_state == S_DRAW) && plot_ready;
    assign w_last   = (r_px == r_x1) && (r_py == r_y1);
    assign w_dx_abs = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_dy_abs = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
    assign w_e2     = r_err <<< 1;
    assign w_step_x = (w_e2 >= r_dy);
    assign w_step_y = (w_e2 <= r_dx);
    assign w_err_a  = w_step_x ? (r_err + r_dy) : r_err;
    assign w_err_n  = w_step_y ? (w_err_a + r_dx) : w_err_a;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        plot_valid  = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_SETUP;
            end
            S_SETUP: w_next = S_DRAW;
            S_DRAW: begin
                plot_valid = 1'b1;
                if (w_xfer && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_px     <= '0;
            r_py     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x0 <= x0;
                        r_y0 <= y0;
                        r_x1 <= x1;
                        r_y1 <= y1;
                    end
                end
                S_SETUP: begin
                    // dx is non-negative, dy non-positive; three guard bits keep 2*err in range.
                    r_sx_neg <= (r_x1 < r_x0);
                    r_sy_neg <= (r_y1 < r_y0);
                    r_dx     <= $signed({3'b000, w_dx_abs});
                    r_dy     <= -$signed({3'b000, w_dy_abs});
                    r_err    <= $signed({3'b000, w_dx_abs}) - $signed({3'b000, w_dy_abs});
                    r_px     <= r_x0;
                    r_py     <= r_y0;
                end
                S_DRAW: begin
                    if (w_xfer && !w_last) begin
                        r_err <= w_err_n;
                        if (w_step_x) r_px <= r_sx_neg ? (r_px - ONE) : (r_px + ONE);
                        if (w_step_y) r_py <= r_sy_neg ? (r_py - ONE) : (r_py + ONE);
                    end
                end
                default: ;
            endcase
        end
    end

    assign px          = r_px;
    assign py          = r_py;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: hand-computed pixel lists are queued and matched
// against every transfer, with backpressure, reset-abort and start-timing cases.
module tb_line_drawer;

    logic       Clk;
    logic       Reset_n;
    logic       start;
    logic [8:0] x0, y0, x1, y1;
    logic       plot_valid;
    logic       plot_ready;
    logic [8:0] px, py;
    logic       busy;
    logic       done;
    logic [1:0] o_dbg_state;

    logic [17:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    line_drawer #(.CW(9)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .plot_valid  (plot_valid),
        .plot_ready  (plot_ready),
        .px          (px),
        .py          (py),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (o_dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_px(input int x, input int y);
        logic [8:0] vx;
        logic [8:0] vy;
        vx = x[8:0];
        vy = y[8:0];
        exp_q.push_back({vx, vy});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, plot_valid, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_px"}, px, 0);
        check_val({tag, "_py"}, py, 0);
        check_val({tag, "_state"}, o_dbg_state, 0);
    endtask

    // bp=0: ready always high; bp=1: ready pattern 1,0,0 repeating.
    // abort_after>0: pull reset right after that many transfers and return.
    task automatic run_line(input logic [8:0] ax0, input logic [8:0] ay0,
                            input logic [8:0] ax1, input logic [8:0] ay1,
                            input int bp, input int abort_after);
        int          xfers;
        int          cyc;
        logic        held;
        logic [17:0] held_v;
        logic [17:0] e;
        xfers  = 0;
        cyc    = 0;
        held   = 1'b0;
        held_v = '0;
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("setup_busy", busy, 1);
        check_val("setup_valid", plot_valid, 0);
        x0 = 9'($urandom_range(0, 511));
        y0 = 9'($urandom_range(0, 511));
        x1 = 9'($urandom_range(0, 511));
        y1 = 9'($urandom_range(0, 511));
        tick();
        check_val("first_valid", plot_valid, 1);
        while (plot_valid && cyc < 3000) begin
            if (held) check_val("hold", {px, py}, held_v);
            plot_ready = (bp == 0) || (cyc % 3 == 0);
            if (plot_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_pixel", plot_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("pixel", {px, py}, e);
                end
                xfers++;
            end
            held   = !plot_ready;
            held_v = {px, py};
            cyc++;
            tick();
            if (abort_after != 0 && xfers == abort_after) begin
                Reset_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_q.delete();
                plot_ready = 1'b0;
                return;
            end
        end
        plot_ready = 1'b0;
        check_val("timeout", (cyc < 3000), 1);
        check_val("pixel_count", exp_q.size(), 0);
        if (bp == 0) check_val("one_per_cycle", cyc, xfers);
        check_val("done_pulse", done, 1);
        check_val("done_valid", plot_valid, 0);
        check_val("done_busy", busy, 1);
    endtask

    task automatic finish_done();
        tick();
        check_val("idle_done", done, 0);
        check_val("idle_busy", busy, 0);
    endtask

    initial begin
        Reset_n    = 1'b0;
        start      = 1'b0;
        plot_ready = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        tick();
        check_val("idle_after_reset", busy, 0);

        // horizontal (2,5)->(6,5)
        for (int i = 2; i <= 6; i++) push_px(i, 5);
        run_line(9'd2, 9'd5, 9'd6, 9'd5, 0, 0);
        finish_done();

        // steep reverse (3,9)->(1,3)
        push_px(3, 9); push_px(3, 8); push_px(2, 7); push_px(2, 6);
        push_px(2, 5); push_px(1, 4); push_px(1, 3);
        run_line(9'd3, 9'd9, 9'd1, 9'd3, 0, 0);
        finish_done();

        // diagonal under backpressure
        for (int i = 0; i <= 4; i++) push_px(i, i);
        run_line(9'd0, 9'd0, 9'd4, 9'd4, 1, 0);
        finish_done();

        // single point, then start raised during the DONE cycle
        push_px(511, 511);
        run_line(9'd511, 9'd511, 9'd511, 9'd511, 0, 0);
        start = 1'b1;
        x0 = 9'd1; y0 = 9'd1; x1 = 9'd2; y1 = 9'd2;
        tick();
        check_val("done_start_ignored", busy, 0);
        check_val("done_start_state", o_dbg_state, 0);
        push_px(1, 1); push_px(2, 2);
        run_line(9'd1, 9'd1, 9'd2, 9'd2, 0, 0);
        finish_done();

        // extreme span (0,0)->(511,1): y steps after pixel 255
        for (int i = 0; i <= 511; i++) push_px(i, (i >= 256) ? 1 : 0);
        run_line(9'd0, 9'd0, 9'd511, 9'd1, 0, 0);
        finish_done();

        // reset after the 10th transfer, then a fresh line
        for (int i = 0; i <= 100; i++) push_px(i, 0);
        run_line(9'd0, 9'd0, 9'd100, 9'd0, 0, 10);
        tick();
        check_val("abort_no_done", done, 0);
        check_val("abort_no_valid", plot_valid, 0);
        Reset_n = 1'b1;
        tick();
        check_val("abort_idle", busy, 0);
        push_px(1, 1); push_px(2, 2);
        run_line(9'd1, 9'd1, 9'd2, 9'd2, 0, 0);
        finish_done();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
